updown_counter_n: RTL
=====================

# updown_counter_n

Parametrised up/down counter generalising the team's fixed 2-bit up counter to any width and modulus. Adds direction control, count enable with a prescaler, parallel load, synchronous clear, wrap or saturate mode, a terminal-count pulse and sticky overflow/underflow flags. It is the general-purpose counting primitive for timers, address generators and the board-level demo counters.

## Interface
- WIDTH, 4: counter width in bits.
- MOD, 16: count range 0..MOD-1; legal range 2 <= MOD <= 2^WIDTH.
- PRESCALE, 1: number of enabled cycles per count step; >= 1.
- SATURATE, 0: 0 = wrap at the limits, 1 = hold at the limits.

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- en  in  1  count enable; advances the prescaler.
- up  in  1  direction: 1 = count up, 0 = count down.
- clr  in  1  synchronous clear of count and prescaler.
- load  in  1  synchronous parallel load.
- d  in  WIDTH  load value.
- flag_clr  in  1  synchronous clear of ovf/unf.
- c  out  WIDTH  registered count value.
- tc  out  1  registered 1-cycle terminal-count pulse.
- ovf  out  1  sticky: an up-step was attempted at MOD-1.
- unf  out  1  sticky: a down-step was attempted at 0.

## Operation
- Internal prescaler ps, range 0..PRESCALE-1, width clog2(PRESCALE) (min 1).
- Priority per edge: clr > load > en. Lower-priority actions are ignored that cycle.
- clr: c <= 0, ps <= 0, tc <= 0. Flags are not touched.
- load: c <= d if d <= MOD-1, else c <= MOD-1 (clamp); ps <= 0; tc <= 0.
- en (no clr/load): if ps == PRESCALE-1, a step occurs and ps <= 0; otherwise ps <= ps+1 and no step. With PRESCALE=1, every enabled cycle steps.
- Step up: c < MOD-1 gives c+1. At c == MOD-1: wrap mode gives c <= 0; saturate mode holds c. In both modes tc <= 1 and ovf <= 1.
- Step down: c > 0 gives c-1. At c == 0: wrap mode gives c <= MOD-1; saturate mode holds c. In both modes tc <= 1 and unf <= 1.
- tc is 0 on every edge without a boundary step.
- en low: c and ps hold, tc <= 0.
- A change of up takes effect on the next step. The prescaler phase is kept.
- flag_clr clears ovf and unf. If a set event happens on the same edge, the set wins.
- All arithmetic is in WIDTH bits. With MOD = 2^WIDTH, wrap equals natural binary overflow.

## Timing
- Reset (reset = 0) acts immediately, independent of clk: c = 0, ps = 0, tc = 0, ovf = 0, unf = 0.
- Outputs are held in reset while reset = 0. The first action is on the first rising edge after reset = 1.
- Reset asserted mid-count or mid-prescale discards all state. There is no partial step.
- Latency is 1 cycle from a sampled en/clr/load to the updated c. tc and the flags update on the same edge as the step that causes them.
- tc is high for exactly 1 cycle per boundary step. Back-to-back boundary steps (saturate mode, PRESCALE=1) keep tc high continuously.
- A step that reaches a boundary without crossing it (for example 8 to 9 with MOD=10) does not assert tc.

## Test plan
- Wrap up, WIDTH=4, MOD=10, PRESCALE=1, SATURATE=0: release reset, en=1, up=1 for 12 cycles. Required: c = 1..9, 0, 1, 2. tc is high only in the cycle c becomes 0. ovf = 1 from then on.
- Wrap down, same config: load d=2, then en=1, up=0 for 4 cycles. Required: c = 2, 1, 0, 9, 8. tc pulses with c = 9. unf = 1. flag_clr then gives ovf = unf = 0.
- Saturate, MOD=10, SATURATE=1: load 8, up for 4 steps. Required: c = 9, 9, 9, 9. tc is high for the last 3 cycles. ovf = 1. Load d=15 then gives c = 9 (clamp).
- Prescale, PRESCALE=3, MOD=16: en=1 for 9 cycles. Required: c steps 0 to 1 to 2 to 3 on cycles 3, 6 and 9. Dropping en for 2 cycles mid-phase holds both c and ps.
- Priority: clr=load=en=1 with d=5 gives c = 0. load=en=1 with d=5 gives c = 5 and ps = 0. flag_clr together with an ovf-setting step leaves ovf = 1.
- Async reset: assert reset=0 between clock edges at c=7, ps=1. Required: all outputs 0 before the next edge. Release reset, and the first enabled step (PRESCALE=1) gives c = 1.

Source files
------------

// File: rtl/updown_counter_n.sv
// rtl/updown_counter_n.sv - parametrised up/down counter with prescaler, load, clear and sticky flags
//
// Purpose: general-purpose counting primitive. Counts 0..MOD-1 in either
// direction, one step every PRESCALE enabled cycles, wrapping or saturating
// at the limits, with a one-cycle terminal-count pulse and sticky
// overflow/underflow flags.
//
// Ports:
//   clk       in   clock, rising edge active
//   reset     in   asynchronous active-low reset
//   en        in   count enable (advances the prescaler)
//   up        in   direction, 1 = up, 0 = down
//   clr       in   synchronous clear of count and prescaler
//   load      in   synchronous parallel load of d (clamped to MOD-1)
//   d         in   load value
//   flag_clr  in   synchronous clear of ovf/unf
//   c         out  registered count
//   tc        out  registered terminal-count pulse
//   ovf       out  sticky overflow flag
//   unf       out  sticky underflow flag

module updown_counter_n #(
    parameter int WIDTH    = 4,
    parameter int MOD      = 16,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] c,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // The modulus may equal 2^WIDTH, so the top count is computed as an
    // integer before truncation to WIDTH bits.
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MOD - 1);
    localparam logic [PSW-1:0]   PS_LAST = PSW'(PRESCALE - 1);

    logic [WIDTH-1:0] c_q,   c_d;
    logic [PSW-1:0]   ps_q,  ps_d;
    logic             tc_q,  tc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    always_comb begin
        c_d   = c_q;
        ps_d  = ps_q;
        tc_d  = 1'b0;
        // Clearing first lets a same-edge set event below win.
        ovf_d = flag_clr ? 1'b0 : ovf_q;
        unf_d = flag_clr ? 1'b0 : unf_q;

        if (clr) begin
            c_d  = '0;
            ps_d = '0;
        end else if (load) begin
            c_d  = (d > MAX_CNT) ? MAX_CNT : d;
            ps_d = '0;
        end else if (en) begin
            if (ps_q == PS_LAST) begin
                ps_d = '0;
                if (up) begin
                    if (c_q == MAX_CNT) begin
                        tc_d  = 1'b1;
                        ovf_d = 1'b1;
                        if (SATURATE == 0) begin
                            c_d = '0;
                        end
                    end else begin
                        c_d = c_q + WIDTH'(1);
                    end
                end else begin
                    if (c_q == '0) begin
                        tc_d  = 1'b1;
                        unf_d = 1'b1;
                        if (SATURATE == 0) begin
                            c_d = MAX_CNT;
                        end
                    end else begin
                        c_d = c_q - WIDTH'(1);
                    end
                end
            end else begin
                ps_d = ps_q + PSW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_q   <= '0;
            ps_q  <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            c_q   <= c_d;
            ps_q  <= ps_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign c   = c_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;
    assign unf = unf_q;

endmodule
